mul_div_iter: RTL and testbench

MUL_DIV_ITER -- requirements
Module: mul_div_iter

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_div_step.sv | 18 +
 rtl/mul_div_iter.sv | 165 ++++++++++++++++
 tb/tb_mul_div_iter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Op and state encodings for the iterative multiply/divide unit.
// The EX stage and its issue logic share these encodings.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    // The kept remainder is always below the divisor, so WIDTH bits hold it.
    always_comb begin
        q_o   = (rem_i >= {1'b0, div_i});
        rem_o = q_o ? (rem_i[WIDTH-1:0] - div_i) : rem_i[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_div_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: sign-magnitude operands, one result bit
// per cycle, sign fix-up in FIX, result-valid pulse the cycle after DONE.
module mul_div_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e          state_q, state_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic                div_zero_q, div_zero_d;
    logic                done_q, done_d;

    logic                accept, rs_neg, rt_neg, by_zero;
    logic [WIDTH-1:0]    rs_mag, rt_mag, mul_addend, step_rem;
    logic [WIDTH:0]      mul_sum;
    logic                step_q;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_fix, rem_fix;

    assign accept  = start && !cancel;
    assign rs_neg  = op_is_signed(op) && rs_data[WIDTH-1];
    assign rt_neg  = op_is_signed(op) && rt_data[WIDTH-1];
    assign rs_mag  = rs_neg ? -rs_data : rs_data;
    assign rt_mag  = rt_neg ? -rt_data : rt_data;
    assign by_zero = op_is_div(op) && (rt_data == '0);

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i ({acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}),
        .div_i (opnd_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: each always_comb assigns a default to every output first, so no
    // path through the case leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = by_zero ? ST_DONE : (op_is_div(op) ? ST_DIV : ST_MUL);
            ST_MUL,
            ST_DIV:  if (cancel) state_d = ST_IDLE;
                     else if (cnt_q == CNT_LAST) state_d = ST_FIX;
            ST_FIX:  state_d = cancel ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
        done_d = (state_q == ST_DONE);
    end

    always_comb begin
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        mul_addend = acc_q[0] ? opnd_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        prod_fix   = neg_res_q ? -acc_q : acc_q;
        quo_fix    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (state_q)
            ST_IDLE: if (accept) begin
                // Multiplier / dividend sits in the low half and shifts out LSB / MSB first.
                is_div_d   = op_is_div(op);
                opnd_d     = op_is_div(op) ? rt_mag : rs_mag;
                acc_d      = {{WIDTH{1'b0}}, op_is_div(op) ? rs_mag : rt_mag};
                cnt_d      = '0;
                neg_res_d  = rs_neg ^ rt_neg;
                neg_rem_d  = rs_neg;
                div_zero_d = by_zero;
                if (by_zero) begin
                    lo_d = '1;
                    hi_d = rs_data;
                end
            end
            ST_MUL: if (!cancel) begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_DIV: if (!cancel) begin
                acc_d = {step_rem, acc_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_FIX: if (!cancel) begin
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_iter.sv
// Directed bench for mul_div_iter (WIDTH=32): a vector table of hand-computed
// results plus sequences for cancel, held start, start+cancel and mid-op reset.
module tb_mul_div_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cancel;
    logic [1:0]  op_i;
    logic [31:0] rs_i, rt_i;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        logic        busy;
    } vec_t;

    vec_t vecs[12];

    mul_div_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op_i),
        .rs_data  (rs_i),
        .rt_data  (rt_i),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op_i  = o;
        rs_i  = a;
        rt_i  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts rising edges after the accepting edge until done is seen high.
    task automatic wait_done(output int lat, output logic saw_busy);
        lat      = 0;
        saw_busy = busy;
        while (!done && lat < 60) begin
            tick();
            lat++;
            if (busy) saw_busy = 1'b1;
        end
    endtask

    int   lat;
    logic saw_busy;
    int   done_cnt;

    initial begin
        vecs[0]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34, 1'b1};
        vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1'b1};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b1};
        vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 1'b1};
        vecs[4]  = '{MDU_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1,  1'b0};
        vecs[5]  = '{MDU_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 34, 1'b1};
        vecs[6]  = '{MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 34, 1'b1};
        vecs[7]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 1'b1};
        vecs[8]  = '{MDU_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34, 1'b1};
        vecs[9]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 1'b1};
        vecs[10] = '{MDU_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1,  1'b0};
        vecs[11] = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34, 1'b1};

        rst    = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op_i   = 2'b00;
        rs_i   = '0;
        rt_i   = '0;

        @(negedge clk);
        @(negedge clk);
        check("reset busy",     64'(busy),     64'd0);
        check("reset done",     64'(done),     64'd0);
        check("reset hi",       64'(hi),       64'd0);
        check("reset lo",       64'(lo),       64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);

        // First vector is issued in the same cycle reset is released.
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_done(lat, saw_busy);
            check($sformatf("v%0d latency", i),  64'(lat),      64'(vecs[i].lat));
            check($sformatf("v%0d busy", i),     64'(saw_busy), 64'(vecs[i].busy));
            check($sformatf("v%0d hi", i),       64'(hi),       64'(vecs[i].hi));
            check($sformatf("v%0d lo", i),       64'(lo),       64'(vecs[i].lo));
            check($sformatf("v%0d div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
            tick();
            check($sformatf("v%0d done pulse", i), 64'(done), 64'd0);
        end

        // Cancel ten cycles into a MULT: no done, previous result kept.
        issue(MDU_MULT, 32'h00000003, 32'h00000005);
        for (int k = 0; k < 9; k++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check("cancel no done", 64'(done_cnt), 64'd0);
        check("cancel hi kept", 64'(hi), 64'h1);
        check("cancel lo kept", 64'(lo), 64'h23456780);

        // Start held through the operation with different operands: ignored.
        op_i  = MDU_MULTU;
        rs_i  = 32'h2;
        rt_i  = 32'h3;
        start = 1'b1;
        tick();
        op_i  = MDU_DIVU;
        rs_i  = 32'h64;
        rt_i  = 32'h0;
        wait_done(lat, saw_busy);
        start = 1'b0;
        check("held start latency",  64'(lat),      64'd34);
        check("held start hi",       64'(hi),       64'h0);
        check("held start lo",       64'(lo),       64'h6);
        check("held start div_zero", 64'(div_zero), 64'd0);
        tick();
        check("held start idle", 64'(busy | done), 64'd0);

        // Start and cancel together in IDLE: nothing accepted.
        op_i   = MDU_DIVU;
        rs_i   = 32'h64;
        rt_i   = 32'h0;
        start  = 1'b1;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        tick();
        check("start+cancel done",     64'(done),     64'd0);
        check("start+cancel div_zero", 64'(div_zero), 64'd0);
        check("start+cancel hi",       64'(hi),       64'h0);
        check("start+cancel lo",       64'(lo),       64'h6);

        // Reset mid-DIV clears outputs asynchronously; new op starts right after release.
        issue(MDU_DIV, 32'h12345678, 32'h00000003);
        for (int k = 0; k < 5; k++) tick();
        #2 rst = 1'b0;
        #1;
        check("async rst busy",     64'(busy),     64'd0);
        check("async rst done",     64'(done),     64'd0);
        check("async rst hi",       64'(hi),       64'd0);
        check("async rst lo",       64'(lo),       64'd0);
        check("async rst div_zero", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(MDU_DIVU, 32'h00000009, 32'h00000004);
        wait_done(lat, saw_busy);
        check("post rst latency", 64'(lat), 64'd34);
        check("post rst lo",      64'(lo),  64'h2);
        check("post rst hi",      64'(hi),  64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
